// File: rtl/adder_op_sched.sv
// adder_op_sched
//   Round-robin scheduler that shares one external chunked W-bit adder among
//   NREQ requesters. A granted operand set is registered onto add_a/add_b/
//   add_cin and held for the full adder pass. This hold matters because the
//   adder stages read the operand bits directly. After LAT edges the adder
//   result is captured and returned for one cycle, tagged with the id of the
//   requester.
//
//   Ports
//     clk, rst_n              rising-edge clock, async active-low reset
//     req_valid[NREQ]         request pending per requester
//     req_ready[NREQ]         combinational grant, one-hot or zero, IDLE only
//     req_a/req_b[NREQ*W]     operands, requester i at [i*W +: W]
//     req_cin[NREQ]           carry-in per requester
//     add_a/add_b/add_cin     registered operands to the adder
//     add_sum/add_cout        adder result (cout = sign of W+1-bit sum)
//     rsp_valid               one-cycle result strobe, no backpressure
//     rsp_id/rsp_sum/rsp_cout captured result, held while rsp_valid is low
//     rsp_ovf                 signed overflow flag (ADD_SCHED_OVF_EN only)
//     busy                    high while a pass is in flight (state != IDLE)
//
//   Build option: define ADD_SCHED_OVF_EN to add the rsp_ovf output.
module adder_op_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned LAT  = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic [W-1:0]      add_a,
    output logic [W-1:0]      add_b,
    output logic              add_cin,
    input  logic [W-1:0]      add_sum,
    input  logic              add_cout,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
`ifdef ADD_SCHED_OVF_EN
    output logic              rsp_ovf,
`endif
    output logic              busy
);

    localparam int unsigned CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   add_a_q, add_a_d;
    logic [W-1:0]   add_b_q, add_b_d;
    logic           add_cin_q, add_cin_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_sum_q, rsp_sum_d;
    logic           rsp_cout_q, rsp_cout_d;
    logic           busy_q, busy_d;
`ifdef ADD_SCHED_OVF_EN
    logic           rsp_ovf_q, rsp_ovf_d;
`endif

    // Operand lanes unpacked so the granted lane can be picked by index.
    logic [W-1:0] lane_a [NREQ];
    logic [W-1:0] lane_b [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        assign lane_a[gi] = req_a[gi*W +: W];
        assign lane_b[gi] = req_b[gi*W +: W];
    end

    // Round-robin pick: scan rr_ptr, rr_ptr+1, ... with an explicit wrap so
    // non power-of-two NREQ never produces an id >= NREQ.
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW:0]   scan_idx;
    logic [IDW:0]   ptr_nxt;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        if (state_q == S_IDLE) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                scan_idx = {1'b0, rr_ptr_q} + (IDW+1)'(i);
                if (scan_idx >= (IDW+1)'(NREQ)) begin
                    scan_idx = scan_idx - (IDW+1)'(NREQ);
                end
                if (!gnt_found && req_valid[scan_idx[IDW-1:0]]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = scan_idx[IDW-1:0];
                end
            end
        end
        ptr_nxt = {1'b0, gnt_idx} + (IDW+1)'(1);
        if (ptr_nxt >= (IDW+1)'(NREQ)) begin
            ptr_nxt = '0;
        end
    end

    assign req_ready = gnt_found ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
`ifdef ADD_SCHED_OVF_EN
        rsp_ovf_d   = rsp_ovf_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    add_a_d   = lane_a[gnt_idx];
                    add_b_d   = lane_b[gnt_idx];
                    add_cin_d = req_cin[gnt_idx];
                    id_d      = gnt_idx;
                    rr_ptr_d  = ptr_nxt[IDW-1:0];
                    cnt_d     = '0;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                // Operands stay put; leave after the LAT-th edge since launch.
                cnt_d = cnt_q + CW'(1);
                if (cnt_d == CW'(LAT)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                rsp_sum_d   = add_sum;
                rsp_cout_d  = add_cout;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
`ifdef ADD_SCHED_OVF_EN
                rsp_ovf_d   = add_cout ^ add_sum[W-1];
`endif
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ADD_SCHED_OVF_EN
            rsp_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            busy_q      <= busy_d;
`ifdef ADD_SCHED_OVF_EN
            rsp_ovf_q   <= rsp_ovf_d;
`endif
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = busy_q;
`ifdef ADD_SCHED_OVF_EN
    assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_adder_op_sched.sv
// tb_adder_op_sched
//   Directed bench for adder_op_sched. Contains a model of the external
//   chunked adder: four registered 2-bit stages with a carry chain, where
//   each stage reads the operand bits directly and the top chunk is
//   sign-extended. As a result, add_sum is only correct LAT edges after the
//   operands launch.
module tb_adder_op_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ-1:0]   req_cin = '0;
    logic [W-1:0]      add_a, add_b;
    logic              add_cin;
    logic [W-1:0]      add_sum;
    logic              add_cout;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
    logic              busy;
`ifdef ADD_SCHED_OVF_EN
    logic              rsp_ovf;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    adder_op_sched #(.NREQ(NREQ), .W(W), .LAT(4), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
`ifdef ADD_SCHED_OVF_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External chunked adder model.
    logic [1:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
    logic       c0 = 1'b0, c1 = 1'b0, c2 = 1'b0, c3 = 1'b0;
    always @(posedge clk) begin
        {c0, s0} <= {1'b0, add_a[1:0]} + {1'b0, add_b[1:0]} + {2'b00, add_cin};
        {c1, s1} <= {1'b0, add_a[3:2]} + {1'b0, add_b[3:2]} + {2'b00, c0};
        {c2, s2} <= {1'b0, add_a[5:4]} + {1'b0, add_b[5:4]} + {2'b00, c1};
        {c3, s3} <= {add_a[7], add_a[7:6]} + {add_b[7], add_b[7:6]} + {2'b00, c2};
    end
    assign add_sum  = {s3, s2, s1, s0};
    assign add_cout = c3;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic cin);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_cin[id]      = cin;
    endtask

    // Counts edges after the accept edge until rsp_valid, bounded.
    task automatic wait_rsp(output int cycles);
        cycles = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            cycles++;
            if (rsp_valid) break;
        end
    endtask

    task automatic check_rsp(input string tag, input int id, input logic [7:0] sum,
                             input logic cout, input logic ovf);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " rsp_id"},    32'(rsp_id),    32'(id));
        check({tag, " rsp_sum"},   32'(rsp_sum),   32'(sum));
        check({tag, " rsp_cout"},  32'(rsp_cout),  32'(cout));
`ifdef ADD_SCHED_OVF_EN
        check({tag, " rsp_ovf"},   32'(rsp_ovf),   32'(ovf));
`else
        if (ovf === 1'bx) check({tag, " ovf arg"}, 32'(ovf), 32'd0);
`endif
    endtask

    // Single isolated operation on requester id.
    task automatic do_op(input string tag, input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [7:0] sum, input logic cout, input logic ovf);
        int cyc;
        set_req(id, a, b, cin);
        req_valid = 4'(1 << id);
        #1;
        check({tag, " req_ready"}, 32'(req_ready), 32'(1 << id));
        tick();
        req_valid = '0;
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " add_a"}, 32'(add_a), 32'(a));
        check({tag, " add_b"}, 32'(add_b), 32'(b));
        check({tag, " add_cin"}, 32'(add_cin), 32'(cin));
        check({tag, " ready idle"}, 32'(req_ready), 32'd0);
        wait_rsp(cyc);
        check({tag, " latency"}, 32'(cyc), 32'd5);
        check_rsp(tag, id, sum, cout, ovf);
    endtask

    initial begin
        int cyc;
        logic [7:0] t2_a [4];
        logic [7:0] t2_b [4];
        logic       t2_c [4];
        logic [7:0] t2_s [4];
        logic       t2_co [4];
        logic       t2_ov [4];

        // Reset state
        #2;
        check("rst busy", 32'(busy), 32'd0);
        check("rst add_a", 32'(add_a), 32'd0);
        check("rst add_cin", 32'(add_cin), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_sum", 32'(rsp_sum), 32'd0);
        check("rst req_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle no grant", 32'(req_ready), 32'd0);

        // 1: 35+4A+1 = 80, signed overflow
        do_op("t1", 0, 8'h35, 8'h4A, 1'b1, 8'h80, 1'b0, 1'b1);
        tick();
        check("t1 strobe drop", 32'(rsp_valid), 32'd0);
        check("t1 sum hold", 32'(rsp_sum), 32'h80);
        check("t1 add_a hold", 32'(add_a), 32'h35);
        check("t1 busy idle", 32'(busy), 32'd0);

        // 4: boundaries
        do_op("t4a", 1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0);
        do_op("t4b", 2, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        // 5: operand change after accept is ignored
        set_req(3, 8'h10, 8'h20, 1'b0);
        req_valid = 4'b1000;
        #1;
        check("t5 req_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        set_req(3, 8'hAA, 8'h20, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("t5 add_a held", 32'(add_a), 32'h10);
            tick();
        end
        check("t5 add_a held", 32'(add_a), 32'h10);
        tick();
        check_rsp("t5", 3, 8'h30, 1'b0, 1'b0);

        // 3: rr_ptr now 0; grant 2, then req0+req3 pending -> 3 before 0
        set_req(2, 8'h12, 8'h34, 1'b0);
        req_valid = 4'b0100;
        #1;
        check("t3 grant2", 32'(req_ready), 32'h4);
        tick();
        set_req(0, 8'h55, 8'h55, 1'b1);
        set_req(3, 8'hC0, 8'hC0, 1'b1);
        req_valid = 4'b1001;
        #1;
        check("t3 no grant busy", 32'(req_ready), 32'd0);
        wait_rsp(cyc);
        check("t3 lat2", 32'(cyc), 32'd5);
        check_rsp("t3 r2", 2, 8'h46, 1'b0, 1'b0);
        check("t3 grant3", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b0001;
        wait_rsp(cyc);
        check("t3 lat3", 32'(cyc), 32'd5);
        check_rsp("t3 r3", 3, 8'h81, 1'b1, 1'b0);
        check("t3 grant0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        wait_rsp(cyc);
        check("t3 lat0", 32'(cyc), 32'd5);
        check_rsp("t3 r0", 0, 8'hAB, 1'b0, 1'b1);

        // 2: all valid at reset release -> 0,1,2,3 every 6 cycles
        t2_a = '{8'h01, 8'h40, 8'h80, 8'hF0};
        t2_b = '{8'h02, 8'h40, 8'h80, 8'h05};
        t2_c = '{1'b0, 1'b0, 1'b0, 1'b1};
        t2_s = '{8'h03, 8'h80, 8'h00, 8'hF6};
        t2_co = '{1'b0, 1'b0, 1'b1, 1'b1};
        t2_ov = '{1'b0, 1'b1, 1'b1, 1'b0};
        tick();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) set_req(k, t2_a[k], t2_b[k], t2_c[k]);
        req_valid = 4'b1111;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t2 grant", 32'(req_ready), 32'(1 << k));
            tick();
            req_valid[k] = 1'b0;
            wait_rsp(cyc);
            check("t2 spacing", 32'(cyc), 32'd5);
            check_rsp("t2", k, t2_s[k], t2_co[k], t2_ov[k]);
        end

        // 6: reset at cnt==2 discards op and rewinds rr_ptr
        tick();
        set_req(2, 8'h11, 8'h22, 1'b0);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t6 busy", 32'(busy), 32'd0);
        check("t6 add_a", 32'(add_a), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6 no rsp", 32'(rsp_valid), 32'd0);
        end
        set_req(1, 8'h03, 8'h04, 1'b1);
        set_req(3, 8'h99, 8'h99, 1'b0);
        req_valid = 4'b1010;
        rst_n = 1'b1;
        #1;
        check("t6 grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        wait_rsp(cyc);
        check("t6 lat", 32'(cyc), 32'd5);
        check_rsp("t6", 1, 8'h08, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
